// File: rtl/frame_accum_pkg.sv
// frame_accum_pkg: shared FSM state encoding and width helper for the frame accumulator
package frame_accum_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/frame_accum_sat_add.sv
// sat_add: signed a+b with overflow flag and optional clamp to the signed W-bit range
module sat_add #(
    parameter int W   = 40,
    parameter int SAT = 1
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    localparam logic signed [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] ACC_MIN = {1'b1, {(W-1){1'b0}}};

    logic signed [W-1:0] raw;

    // overflow only when same-signed operands produce a result of the other sign
    always_comb begin
        raw = a + b;
        ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
        sum = (SAT != 0 && ovf) ? (a[W-1] ? ACC_MIN : ACC_MAX) : raw;
    end

endmodule

// File: rtl/frame_accum.sv
// frame_accum: sums up to LEN signed samples per frame and hands out one result per frame
module frame_accum
    import frame_accum_pkg::*;
#(
    parameter int NN    = 16,
    parameter int ACC_W = 40,
    parameter int LEN   = 8,
    parameter int SAT   = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [NN-1:0]           in,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [ACC_W-1:0]        out,
    output logic                           out_ovf,
    output logic [clog2(LEN+1)-1:0]        out_cnt
);

    localparam int CW = clog2(LEN + 1);

    state_t                   state, state_nxt;
    logic signed [ACC_W-1:0]  acc, ext, nxt;
    logic [CW-1:0]            cnt;
    logic                     ovf, this_ovf, accept, deliver, frame_end;

    assign ext       = {{(ACC_W-NN){in[NN-1]}}, in};
    assign out_valid = (state == ST_HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
    assign frame_end = accept && (cnt == CW'(LEN - 1) || in_last);

    // acc is already cleared while a result waits, so a sample taken in the Deliver cycle starts fresh
    sat_add #(.W(ACC_W), .SAT(SAT)) u_add (
        .a   (acc),
        .b   (ext),
        .sum (nxt),
        .ovf (this_ovf)
    );

    // state register
    always_ff @(posedge clk)
        if (reset) state <= ST_ACC;
        else       state <= state_nxt;

    // a frame end always (re)loads HOLD; an undelivered result keeps HOLD; otherwise accumulate
    always_comb
        state_nxt = frame_end ? ST_HOLD : (out_valid && !deliver) ? ST_HOLD : ST_ACC;

    // accumulator, sample counter, sticky overflow and result registers
    always_ff @(posedge clk)
        if (reset) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            out     <= '0;
            out_ovf <= 1'b0;
            out_cnt <= '0;
        end else if (frame_end) begin
            out     <= nxt;
            out_ovf <= ovf || this_ovf;
            out_cnt <= cnt + CW'(1);
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
        end else if (accept) begin
            acc     <= nxt;
            cnt     <= cnt + CW'(1);
            ovf     <= ovf || this_ovf;
        end

endmodule
